trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
// - Consumes the hazard unit's trap request (controlReset + mcause) and mret, and owns the M-mode trap CSRs.
// - On trap entry it captures the trapping PC, cause and value into CSRs, then issues a one-shot PC redirect to mtvec.
// - On mret it issues a redirect to mepc and restores mstatus.MIE.
// - Sits beside the fetch PC mux; it is the responder to the hazard unit's trap/flush initiator.
// PARAMETERS
// - RESET_VECTOR  32'h0000_0000  reset value of mtvec; the trap target until software writes mtvec
// - XLEN          32             CSR and PC width
// PORTS
// - clock             in   1     single clock; all state on rising edge
// - reset             in   1     asynchronous, active-low reset
// - controlReset      in   1     trap request, one cycle, from hazard unit
// - mcause            in   4     exception code accompanying controlReset
// - trapPc            in   XLEN  PC of the trapping instruction
// - trapValue         in   XLEN  faulting address/instruction for mtval
// - mretSignal        in   1     mret retiring this cycle
// - stallControl      in   1     global stall; freezes redirect and CSR writes
// - csrReadEnable     in   1     CSR read request
// - csrWriteEnable    in   1     CSR write request
// - csrAddress        in   12    CSR address
// - csrWriteData      in   XLEN  CSR write value
// - csrReadData       out  XLEN  CSR read value, combinational
// - csrIllegal        out  1     access to an unimplemented address, combinational
// - redirectValid     out  1     PC redirect request to fetch
// - redirectPc        out  XLEN  redirect target
// - trapBusy          out  1     FSM not IDLE
// BEHAVIOUR
// - CSRs:
//   - mstatus 0x300: MIE bit 3, MPIE bit 7; other bits read 0.
//   - mtvec 0x305: bits[1:0] forced 0 (direct mode only).
//   - mscratch 0x340: full width.
//   - mepc 0x341: bits[1:0] forced 0.
//   - mcause 0x342: {28'b0, code}; bit 31 is always 0.
//   - mtval 0x343.
// - Reset values: mtvec=RESET_VECTOR; all other CSRs 0; redirectValid=0; redirectPc=0; state=IDLE.
// - Unimplemented address with read or write enable:
//   - csrIllegal=1, csrReadData=0, write discarded.
// - CSR write takes effect at the next edge when csrWriteEnable && !stallControl.
// - FSM states: IDLE, TRAP_REDIRECT, MRET_REDIRECT.
//   - IDLE, controlReset=1:
//     - capture mepc=trapPc, mcause=code, mtval=trapValue, MPIE=MIE, MIE=0;
//     - load redirectPc=mtvec;
//     - go to TRAP_REDIRECT.
//   - IDLE, mretSignal=1 (no controlReset):
//     - redirectPc=mepc, MIE=MPIE, MPIE=1;
//     - go to MRET_REDIRECT.
//   - *_REDIRECT: redirectValid=1.
//     - stallControl=1: hold state and redirectPc.
//     - stallControl=0: return to IDLE at the next edge.
// - Latency: request in cycle N -> redirectValid high in cycle N+1 for exactly 1 cycle absent stall.
// - Simultaneous events:
//   - controlReset && mretSignal: trap wins, mret ignored.
//   - Trap capture and CSR write to the same CSR in one cycle: capture wins.
//   - A CSR write in the same cycle as the mtvec load: redirect uses the old mtvec.
// - controlReset or mretSignal while not IDLE: ignored. The pipeline is already flushed.
// - Reset asserted mid-redirect: redirectValid drops immediately (async); all CSRs return to reset values.
// CONFIGURATION
// - TRAP_MTVAL_EN defined:
//   - mtval is implemented, captured on trap entry and software-writable.
// - TRAP_MTVAL_EN undefined:
//   - mtval reads 0 and is not illegal; writes are discarded.
//   - trapValue is ignored and no mtval register is synthesised.
// TESTING
// - Reset with RESET_VECTOR=0, then controlReset=1, mcause=2, trapPc=0x100:
//   - next cycle redirectValid=1, redirectPc=0;
//   - mepc=0x100, mcause=2.
// - Write mtvec=0x203, then trap with mcause=0xB:
//   - redirectPc=0x200;
//   - mcause reads 0x0000000B;
//   - MIE 1->0 and MPIE=1.
// - After a trap at trapPc=0x44, assert mretSignal:
//   - next cycle redirectPc=0x44;
//   - MIE restored to 1, MPIE=1.
// - controlReset and mretSignal in the same cycle:
//   - trap redirect to mtvec, mepc updated.
//   - Hold stallControl=1 for 3 cycles: redirectValid stays 1, then drops 1 cycle after the stall clears.
// - Read csrAddress=0x7C0:
//   - csrIllegal=1, csrReadData=0.
//   - With TRAP_MTVAL_EN, a trap with trapValue=0xDEAD_BEEF gives mtval=0xDEADBEEF; without it, mtval reads 0.
// - Assert reset low during TRAP_REDIRECT:
//   - redirectValid goes to 0 the same cycle;
//   - mtvec=RESET_VECTOR, mepc=0.

Source files
------------

// File: rtl/trap_controller_if.sv
// Bundles the trap/mret requests, CSR access port and redirect outputs of trap_controller.
// master: hazard unit / pipeline side; slave: trap_controller.
interface trap_controller_if #(
   parameter int unsigned XLEN = 32
);
   logic            controlReset;
   logic [3:0]      mcause;
   logic [XLEN-1:0] trapPc;
   logic [XLEN-1:0] trapValue;
   logic            mretSignal;
   logic            stallControl;
   logic            csrReadEnable;
   logic            csrWriteEnable;
   logic [11:0]     csrAddress;
   logic [XLEN-1:0] csrWriteData;
   logic [XLEN-1:0] csrReadData;
   logic            csrIllegal;
   logic            redirectValid;
   logic [XLEN-1:0] redirectPc;
   logic            trapBusy;

   modport master (
      output controlReset, mcause, trapPc, trapValue, mretSignal, stallControl,
             csrReadEnable, csrWriteEnable, csrAddress, csrWriteData,
      input  csrReadData, csrIllegal, redirectValid, redirectPc, trapBusy
   );

   modport slave (
      input  controlReset, mcause, trapPc, trapValue, mretSignal, stallControl,
             csrReadEnable, csrWriteEnable, csrAddress, csrWriteData,
      output csrReadData, csrIllegal, redirectValid, redirectPc, trapBusy
   );
endinterface

// File: rtl/trap_controller.sv
// M-mode trap CSRs plus one-shot PC redirect on trap entry (to mtvec) and mret (to mepc).
// Optional macro TRAP_MTVAL_EN implements a writable, trap-captured mtval register.
module trap_controller #(
   parameter int unsigned    XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input logic               clock,
   input logic               reset,
   trap_controller_if.slave  bus
);
   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      TRAP_REDIRECT = 2'd1,
      MRET_REDIRECT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [3:0]      r_mcause;
   logic [XLEN-1:0] r_redirect_pc;
`ifdef TRAP_MTVAL_EN
   logic [XLEN-1:0] r_mtval;
`else
   logic            w_unused_trap_value;
   assign w_unused_trap_value = ^bus.trapValue;
`endif

   logic            w_trap_take;
   logic            w_mret_take;
   logic            w_csr_we;
   logic            w_redirect_valid;
   logic            w_csr_hit;
   logic [XLEN-1:0] w_read_data;

   // Requests are only accepted from IDLE; trap has priority over mret.
   assign w_trap_take = (r_state == IDLE) && bus.controlReset;
   assign w_mret_take = (r_state == IDLE) && !bus.controlReset && bus.mretSignal;
   assign w_csr_we    = bus.csrWriteEnable && !bus.stallControl;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_trap_take)      w_state_next = TRAP_REDIRECT;
            else if (w_mret_take) w_state_next = MRET_REDIRECT;
         end
         TRAP_REDIRECT,
         MRET_REDIRECT: begin
            if (!bus.stallControl) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_redirect_valid = (r_state != IDLE);
   end

   // Software writes are issued first so a same-cycle trap capture or mret overrides them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mie         <= 1'b0;
         r_mpie        <= 1'b0;
         r_mtvec       <= {RESET_VECTOR[XLEN-1:2], 2'b00};
         r_mscratch    <= '0;
         r_mepc        <= '0;
         r_mcause      <= 4'd0;
         r_redirect_pc <= '0;
`ifdef TRAP_MTVAL_EN
         r_mtval       <= '0;
`endif
      end else begin
         if (w_csr_we) begin
            case (bus.csrAddress)
               ADDR_MSTATUS: begin
                  r_mie  <= bus.csrWriteData[3];
                  r_mpie <= bus.csrWriteData[7];
               end
               ADDR_MTVEC:    r_mtvec    <= {bus.csrWriteData[XLEN-1:2], 2'b00};
               ADDR_MSCRATCH: r_mscratch <= bus.csrWriteData;
               ADDR_MEPC:     r_mepc     <= {bus.csrWriteData[XLEN-1:2], 2'b00};
               ADDR_MCAUSE:   r_mcause   <= bus.csrWriteData[3:0];
`ifdef TRAP_MTVAL_EN
               ADDR_MTVAL:    r_mtval    <= bus.csrWriteData;
`endif
               default: ;
            endcase
         end
         if (w_trap_take) begin
            r_mepc        <= {bus.trapPc[XLEN-1:2], 2'b00};
            r_mcause      <= bus.mcause;
            r_mpie        <= r_mie;
            r_mie         <= 1'b0;
            r_redirect_pc <= r_mtvec;
`ifdef TRAP_MTVAL_EN
            r_mtval       <= bus.trapValue;
`endif
         end else if (w_mret_take) begin
            r_redirect_pc <= r_mepc;
            r_mie         <= r_mpie;
            r_mpie        <= 1'b1;
         end
      end
   end

   // Combinational CSR read port and illegal-address decode.
   always_comb begin
      w_read_data = '0;
      w_csr_hit   = 1'b1;
      case (bus.csrAddress)
         ADDR_MSTATUS:  w_read_data = XLEN'({r_mpie, 3'b000, r_mie, 3'b000});
         ADDR_MTVEC:    w_read_data = r_mtvec;
         ADDR_MSCRATCH: w_read_data = r_mscratch;
         ADDR_MEPC:     w_read_data = r_mepc;
         ADDR_MCAUSE:   w_read_data = XLEN'(r_mcause);
`ifdef TRAP_MTVAL_EN
         ADDR_MTVAL:    w_read_data = r_mtval;
`else
         ADDR_MTVAL:    w_read_data = '0;
`endif
         default:       w_csr_hit   = 1'b0;
      endcase
   end

   assign bus.csrReadData   = w_read_data;
   assign bus.csrIllegal    = (bus.csrReadEnable || bus.csrWriteEnable) && !w_csr_hit;
   assign bus.redirectValid = w_redirect_valid;
   assign bus.redirectPc    = r_redirect_pc;
   assign bus.trapBusy      = w_redirect_valid;
endmodule

// File: tb/tb_trap_controller.sv
// Directed scenarios plus randomized traffic against a behavioural CSR/redirect model.
module tb_trap_controller;
   localparam int unsigned XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   trap_controller_if #(.XLEN(XLEN)) bus ();

   trap_controller #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   bit          m_mie, m_mpie, m_busy;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mtval, m_rpc;
   logic [3:0]  m_mcause;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_impl(input logic [11:0] a);
      return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) ||
             (a == 12'h341) || (a == 12'h342) || (a == 12'h343);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'(m_mpie) * 128 + 32'(m_mie) * 8;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return 32'(m_mcause);
`ifdef TRAP_MTVAL_EN
         12'h343: return m_mtval;
`else
         12'h343: return 32'h0;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_busy = 0;
      m_mtvec = RV & ~32'h3; m_mscratch = 0; m_mepc = 0; m_mtval = 0; m_rpc = 0; m_mcause = 0;
   endtask

   // One rising edge applied to the model, using the inputs currently on the bus.
   task automatic model_edge();
      bit trap, mret, wr, old_mie, old_mpie;
      logic [31:0] old_mepc, old_mtvec;
      trap = !m_busy && bus.controlReset;
      mret = !m_busy && !bus.controlReset && bus.mretSignal;
      wr   = bus.csrWriteEnable && !bus.stallControl;
      old_mie = m_mie; old_mpie = m_mpie; old_mepc = m_mepc; old_mtvec = m_mtvec;
      if (wr) begin
         case (bus.csrAddress)
            12'h300: begin m_mie = bus.csrWriteData[3]; m_mpie = bus.csrWriteData[7]; end
            12'h305: m_mtvec    = bus.csrWriteData & ~32'h3;
            12'h340: m_mscratch = bus.csrWriteData;
            12'h341: m_mepc     = bus.csrWriteData & ~32'h3;
            12'h342: m_mcause   = bus.csrWriteData[3:0];
            12'h343: m_mtval    = bus.csrWriteData;
            default: ;
         endcase
      end
      if (trap) begin
         m_mepc = bus.trapPc & ~32'h3; m_mcause = bus.mcause; m_mtval = bus.trapValue;
         m_mpie = old_mie; m_mie = 0; m_rpc = old_mtvec; m_busy = 1;
      end else if (mret) begin
         m_rpc = old_mepc; m_mie = old_mpie; m_mpie = 1; m_busy = 1;
      end else if (m_busy && !bus.stallControl) begin
         m_busy = 0;
      end
   endtask

   task automatic clear();
      bus.controlReset = 0; bus.mcause = 0; bus.trapPc = 0; bus.trapValue = 0;
      bus.mretSignal = 0; bus.stallControl = 0; bus.csrReadEnable = 0;
      bus.csrWriteEnable = 0; bus.csrAddress = 0; bus.csrWriteData = 0;
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic step();
      #1;
      check("illegal", 32'(bus.csrIllegal),
            32'((bus.csrReadEnable || bus.csrWriteEnable) && !m_impl(bus.csrAddress)));
      if (bus.csrReadEnable) check("rdata", bus.csrReadData, m_read(bus.csrAddress));
      @(posedge clock);
      model_edge();
      #1;
      check("rvalid", 32'(bus.redirectValid), 32'(m_busy));
      check("busy", 32'(bus.trapBusy), 32'(m_busy));
      check("rpc", bus.redirectPc, m_rpc);
      @(negedge clock);
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                     input logic exp_ill);
      bus.csrAddress = a; bus.csrReadEnable = 1;
      #1;
      check(tag, bus.csrReadData, exp);
      check({tag, "_ill"}, 32'(bus.csrIllegal), 32'(exp_ill));
      bus.csrReadEnable = 0;
   endtask

   task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
      clear(); bus.csrWriteEnable = 1; bus.csrAddress = a; bus.csrWriteData = d;
      step(); clear();
   endtask

   task automatic trap(input logic [3:0] code, input logic [31:0] pc, input logic [31:0] tv);
      clear(); bus.controlReset = 1; bus.mcause = code; bus.trapPc = pc; bus.trapValue = tv;
      step(); clear();
   endtask

   logic [11:0] addrs [8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                               12'h7C0, 12'h301};

   initial begin
      clear();
      model_reset();
      #1;
      check("rst_rvalid", 32'(bus.redirectValid), 32'h0);
      check("rst_rpc", bus.redirectPc, 32'h0);
      @(negedge clock);
      reset = 1;
      rd("rst_mtvec", 12'h305, RV, 0);

      // first trap: redirect to reset vector
      trap(4'd2, 32'h100, 32'h0);
      rd("t1_mepc", 12'h341, 32'h100, 0);
      rd("t1_mcause", 12'h342, 32'h2, 0);
      check("t1_rpc", bus.redirectPc, 32'h0);
      step();
      check("t1_drop", 32'(bus.redirectValid), 32'h0);

      // mtvec low bits masked, MIE saved into MPIE
      wr_csr(12'h305, 32'h203);
      wr_csr(12'h300, 32'h8);
      trap(4'hB, 32'h150, 32'h0);
      check("t2_rpc", bus.redirectPc, 32'h200);
      step();
      rd("t2_mcause", 12'h342, 32'h0000_000B, 0);
      rd("t2_mstatus", 12'h300, 32'h80, 0);

      // mret back to trapping PC
      wr_csr(12'h300, 32'h8);
      trap(4'd3, 32'h44, 32'h0);
      step();
      clear(); bus.mretSignal = 1; step(); clear();
      check("t3_rpc", bus.redirectPc, 32'h44);
      check("t3_rvalid", 32'(bus.redirectValid), 32'h1);
      step();
      rd("t3_mstatus", 12'h300, 32'h88, 0);

      // trap beats mret, stall stretches redirect
      clear(); bus.controlReset = 1; bus.mretSignal = 1; bus.mcause = 4'd7;
      bus.trapPc = 32'h300; step(); clear();
      check("t4_rpc", bus.redirectPc, 32'h200);
      for (int i = 0; i < 3; i++) begin
         bus.stallControl = 1; step();
         check("t4_hold", 32'(bus.redirectValid), 32'h1);
      end
      bus.stallControl = 0; step();
      check("t4_drop", 32'(bus.redirectValid), 32'h0);
      rd("t4_mepc", 12'h341, 32'h300, 0);

      // unimplemented address
      rd("t5_7c0", 12'h7C0, 32'h0, 1);

      // mtval capture
      trap(4'd5, 32'h60, 32'hDEAD_BEEF);
      step();
`ifdef TRAP_MTVAL_EN
      rd("t6_mtval", 12'h343, 32'hDEAD_BEEF, 0);
`else
      rd("t6_mtval", 12'h343, 32'h0, 0);
`endif

      // async reset during a redirect
      trap(4'd1, 32'h80, 32'h0);
      check("t7_pre", 32'(bus.redirectValid), 32'h1);
      reset = 0;
      #1;
      check("t7_rvalid", 32'(bus.redirectValid), 32'h0);
      model_reset();
      @(negedge clock);
      reset = 1;
      rd("t7_mtvec", 12'h305, RV, 0);
      rd("t7_mepc", 12'h341, 32'h0, 0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         clear();
         bus.controlReset = ($urandom % 8) == 0;
         bus.mretSignal   = ($urandom % 8) == 0;
         bus.mcause       = 4'($urandom);
         bus.trapPc       = $urandom;
         bus.trapValue    = $urandom;
         if (m_busy || (!bus.controlReset && !bus.mretSignal))
            bus.stallControl = ($urandom % 3) == 0;
         bus.csrReadEnable  = ($urandom % 2) == 0;
         bus.csrWriteEnable = ($urandom % 4) == 0;
         bus.csrAddress     = addrs[$urandom % 8];
         bus.csrWriteData   = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
